semaforo_ctrl: RTL and testbench

- Two-way traffic-light controller. Drives the 2-bit vehicle signal codes semA/semB consumed by the pedestrian-light block of the same crossing.
- Timed Moore FSM: A green, A yellow, all-red, B green, B yellow, all-red, repeat.
- Advances only on cycles with enb high.

---
 rtl/semaforo_ctrl.sv | 129 ++++++++++++
 tb/tb_semaforo_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/semaforo_ctrl.sv
// Two-way traffic-light controller: timed Moore FSM with registered light codes.
// Optional pedestrian early-exit of green enabled by SEMAFORO_PED_REQ_EN.
module semaforo_ctrl #(
  parameter int T_GREEN     = 8,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1,
  parameter int T_MIN_GREEN = 3,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       ped_req,
  output logic [1:0] semA,
  output logic [1:0] semB,
  output logic [2:0] fase,
  output logic       ped_pend
);

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    RED_AB   = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    RED_BA   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(T_ALLRED - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] last;
  logic             early;
  logic             pend_nx;
  logic [1:0]       sem_a_nx;
  logic [1:0]       sem_b_nx;

`ifdef SEMAFORO_PED_REQ_EN
  localparam logic [CNT_W-1:0] M_LAST = CNT_W'(T_MIN_GREEN - 1);

  logic green;

  always_comb begin
    green   = (state == A_GREEN) || (state == B_GREEN);
    early   = enb && green && ped_pend && (cnt >= M_LAST);
    // the early-exit clear takes priority over a same-edge request
    pend_nx = early ? 1'b0 : (ped_pend | ped_req);
  end
`else
  logic unused_ped;

  assign unused_ped = ped_req | (T_MIN_GREEN == 0);
  assign early      = 1'b0;
  assign pend_nx    = 1'b0;
`endif

  always_comb begin
    last = '0;
    case (state)
      A_GREEN, B_GREEN:   last = G_LAST;
      A_YELLOW, B_YELLOW: last = Y_LAST;
      RED_AB, RED_BA:     last = R_LAST;
      default:            last = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (enb && (early || cnt == last)) begin
      cnt_nx = '0;
      case (state)
        A_GREEN:  state_nx = A_YELLOW;
        A_YELLOW: state_nx = RED_AB;
        RED_AB:   state_nx = B_GREEN;
        B_GREEN:  state_nx = B_YELLOW;
        B_YELLOW: state_nx = RED_BA;
        RED_BA:   state_nx = A_GREEN;
        default:  state_nx = RED_BA;
      endcase
    end else if (enb) begin
      cnt_nx = cnt + CNT_W'(1);
    end
    // codes 6/7 fall back to the all-red before A regardless of enb
    if (state > RED_BA) begin
      state_nx = RED_BA;
      cnt_nx   = '0;
    end
  end

  always_comb begin
    sem_a_nx = 2'b00;
    sem_b_nx = 2'b00;
    case (state_nx)
      A_GREEN:  sem_a_nx = 2'b10;
      A_YELLOW: sem_a_nx = 2'b01;
      B_GREEN:  sem_b_nx = 2'b10;
      B_YELLOW: sem_b_nx = 2'b01;
      default: begin
        sem_a_nx = 2'b00;
        sem_b_nx = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RED_BA;
      cnt      <= '0;
      semA     <= 2'b00;
      semB     <= 2'b00;
      fase     <= 3'd5;
      ped_pend <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      semA     <= sem_a_nx;
      semB     <= sem_b_nx;
      fase     <= state_nx;
      ped_pend <= pend_nx;
    end
  end

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Bench for semaforo_ctrl: position-in-cycle reference model, directed
// literal checks and randomized enb/ped_req/reset stimulus.
module tb_semaforo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb;
  logic       ped_req;
  logic [1:0] semA0, semB0, semA1, semB1;
  logic [2:0] fase0, fase1;
  logic       pend0, pend1;

  int checks = 0;
  int passed = 0;
  bit cmp_on = 0;

  always #5 clk = ~clk;

  semaforo_ctrl u0 (
    .clk(clk), .rst(rst), .enb(enb), .ped_req(ped_req),
    .semA(semA0), .semB(semB0), .fase(fase0), .ped_pend(pend0)
  );

  semaforo_ctrl #(
    .T_GREEN(1), .T_YELLOW(1), .T_ALLRED(1),
    .T_MIN_GREEN(1), .CNT_W(8)
  ) u1 (
    .clk(clk), .rst(rst), .enb(enb), .ped_req(ped_req),
    .semA(semA1), .semB(semB1), .fase(fase1), .ped_pend(pend1)
  );

  int G[2]  = '{8, 1};
  int Y[2]  = '{2, 1};
  int R[2]  = '{1, 1};
  int MG[2] = '{3, 1};
  int pos[2];
  bit pend[2];

  int exp_seq[22] = '{0,0,0,0,0,0,0,0,1,1,2,
                      3,3,3,3,3,3,3,3,4,4,5};

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
  endtask

  // phase from position in the full cycle: A half then B half
  function automatic int fase_of(int g, int y, int r, int p);
    int hp;
    int h;
    int base;
    hp   = g + y + r;
    h    = p % hp;
    base = (p >= hp) ? 3 : 0;
    if (h < g)     return base;
    if (h < g + y) return base + 1;
    return base + 2;
  endfunction

  function automatic int sa_of(int f);
    return (f == 0) ? 2 : (f == 1) ? 1 : 0;
  endfunction

  function automatic int sb_of(int f);
    return (f == 3) ? 2 : (f == 4) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 2; k++) begin
      int  h;
      int  hp;
      bit  early;
      hp = G[k] + Y[k] + R[k];
      if (!rst) begin
        pos[k]  = 2 * hp - R[k];
        pend[k] = 0;
      end else begin
        h     = pos[k] % hp;
        early = 0;
`ifdef SEMAFORO_PED_REQ_EN
        early   = enb && pend[k] && h < G[k] && h >= MG[k] - 1;
        pend[k] = !early && (pend[k] || ped_req);
`endif
        if (enb)
          pos[k] = early ? pos[k] - h + G[k] : (pos[k] + 1) % (2 * hp);
      end
    end
  end

  task automatic cmp_one(int k, int a, int b, int f, int p);
    int ef;
    ef = fase_of(G[k], Y[k], R[k], pos[k]);
    chk($sformatf("fase%0d", k), f, ef);
    chk($sformatf("semA%0d", k), a, sa_of(ef));
    chk($sformatf("semB%0d", k), b, sb_of(ef));
    chk($sformatf("pend%0d", k), p, int'(pend[k]));
    chk($sformatf("no11_%0d", k), int'(a == 3 || b == 3), 0);
    chk($sformatf("safe%0d", k), int'(a != 0 && b != 0), 0);
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      cmp_one(0, semA0, semB0, fase0, pend0);
      cmp_one(1, semA1, semB1, fase1, pend1);
    end
  end

  task automatic wait_fase(int f);
    int k;
    k = 0;
    while (fase0 != 3'(f) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("wait_fase", fase0, f);
  endtask

  initial begin
    int n;
    enb     = 0;
    ped_req = 0;
    #2 rst = 0;
    #1 cmp_on = 1;
    chk("rst_async_fase", fase0, 5);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fase", fase0, 5);
    chk("rst_sem", {semA0, semB0}, 0);

    @(negedge clk);
    rst = 1;
    enb = 1;
    @(posedge clk);
    #1;
    chk("rel_green", semA0, 2);
    chk("seq_0", fase0, exp_seq[0]);
    chk("b1_seq_0", fase1, 0);
    for (int i = 1; i <= 22; i++) begin
      @(posedge clk);
      #1;
      chk("seq", fase0, exp_seq[i % 22]);
      chk("b1_seq", fase1, i % 6);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    enb = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("gate_fase", fase0, 0);
      chk("gate_semA", semA0, 2);
    end
    @(negedge clk);
    enb = 1;
    n = 0;
    while (semA0 == 2'b10 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("gate_len", n + 3, 8);

    wait_fase(0);
    @(posedge clk);
    #3 rst = 0;
    #1;
    chk("mid_rst_fase", fase0, 5);
    chk("mid_rst_sem", {semA0, semB0}, 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("mid_rel_green", semA0, 2);

`ifdef SEMAFORO_PED_REQ_EN
    @(negedge clk);
    ped_req = 1;
    @(negedge clk);
    ped_req = 0;
    chk("ped_set", pend0, 1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (semA0 == 2'b10 && n < 30);
    chk("ped_green_len", n + 1, 3);
    chk("ped_yellow", semA0, 1);
    chk("ped_clr", pend0, 0);

    wait_fase(4);
    @(negedge clk);
    ped_req = 1;
    @(negedge clk);
    ped_req = 0;
    chk("ped_hold", pend0, 1);
    wait_fase(5);
    chk("ped_hold_red", pend0, 1);
    wait_fase(0);
    n = 0;
    while (semA0 == 2'b10 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ped_next_green", n, 3);
`endif

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      enb     = ($urandom_range(3) != 0);
      ped_req = ($urandom_range(9) == 0);
      if ($urandom_range(199) == 0) begin
        #2 rst = 0;
        @(negedge clk);
        rst = 1;
      end
    end
    @(negedge clk);
    @(negedge clk);
    cmp_on = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
